vend_ctrl: RTL and testbench

- Transaction controller for the cola vending datapath.
- Accumulates coin credit in 0.5-yuan units and sequences the dispense actuator through a req/ack handshake.
- Returns change or a refund as paced single-cycle pulses.
- Sits between the coin-detect front end and the dispense mechanism; it is the only owner of the dispense actuator.

---
 rtl/vend_pkg.sv | 22 ++
 rtl/vend_pulse_pacer.sv | 31 +++
 rtl/vend_ctrl.sv | 124 ++++++++++++
 tb/tb_vend_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the cola vending controller: FSM encoding, coin values, credit width.
package vend_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;
  localparam logic [1:0] CHANGE   = 2'd3;

  localparam int COIN_HALF = 1;
  localparam int COIN_ONE  = 2;
  localparam int CREDIT_W  = 4;

  // Both coin pulses in one cycle are worth the sum of the two.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic half, input logic one);
    logic [CREDIT_W-1:0] v;
    v = '0;
    if (half) v = v + CREDIT_W'(COIN_HALF);
    if (one)  v = v + CREDIT_W'(COIN_ONE);
    return v;
  endfunction

endpackage

// File: rtl/vend_pulse_pacer.sv
// Pulse pacer: one pulse on the first enabled cycle, then one every GAP cycles until restarted.
module vend_pulse_pacer #(
  parameter int GAP = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic pulse_o
);

  localparam int CW = $clog2(GAP);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == '0) ? CW'(GAP - 1) : cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pulse_o = en_i && !restart_i && (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Cola vending transaction controller: credit accumulation, dispense handshake,
// paced change/refund return and rejection of coins while busy.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = 5,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CHANGE_GAP  = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  input  logic                pi_cola_ack,
  output logic                po_cola_req,
  output logic                po_change,
  output logic                po_reject,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit
);

  localparam int                  TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE_UNITS);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                reject_q, reject_d;

  logic                coin_any;
  logic [CREDIT_W-1:0] coin_sum;
  logic                in_change;
  logic                change_pulse;

  assign coin_any  = pi_money_half | pi_money_one;
  assign coin_sum  = credit_q + coin_value(pi_money_half, pi_money_one);
  assign in_change = (state_q == CHANGE);

  vend_pulse_pacer #(.GAP(CHANGE_GAP)) u_pacer (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .en_i      (in_change),
    .restart_i (!in_change),
    .pulse_o   (change_pulse)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (coin_any) begin
          if (coin_sum >= PRICE_C) begin
            state_d  = DISPENSE;
            credit_d = coin_sum - PRICE_C;
          end else begin
            state_d  = COLLECT;
            credit_d = coin_sum;
          end
        end
      end
      COLLECT: begin
        // A completing coin wins over a same-cycle cancel.
        if (coin_any && coin_sum >= PRICE_C) begin
          state_d  = DISPENSE;
          credit_d = coin_sum - PRICE_C;
          tmo_d    = '0;
        end else if (pi_cancel) begin
          state_d  = CHANGE;
          credit_d = coin_sum;
          tmo_d    = '0;
        end else if (coin_any) begin
          credit_d = coin_sum;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = CHANGE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DISPENSE: begin
        reject_d = coin_any;
        if (pi_cola_ack)
          state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (change_pulse) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      reject_q <= reject_d;
    end
  end

  assign po_cola_req = (state_q == DISPENSE);
  assign po_busy     = (state_q == DISPENSE) || (state_q == CHANGE);
  assign po_change   = change_pulse;
  assign po_reject   = reject_q;
  assign po_credit   = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized purchases
// and cancels, predicted from the pricing and refund rules with plain arithmetic.
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int TMO   = 1000;
  localparam int GAP   = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       half = 1'b0, one = 1'b0, cancel = 1'b0, ack = 1'b0;
  logic       po_cola_req, po_change, po_reject, po_busy;
  logic [3:0] po_credit;

  int n_checks = 0;
  int n_pass   = 0;

  int pulse_at[$];
  int pulse_cred[$];
  int idle_at;

  vend_ctrl #(.PRICE_UNITS(PRICE), .TIMEOUT_CYC(TMO), .CHANGE_GAP(GAP)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .pi_money_half (half),
    .pi_money_one  (one),
    .pi_cancel     (cancel),
    .pi_cola_ack   (ack),
    .po_cola_req   (po_cola_req),
    .po_change     (po_change),
    .po_reject     (po_reject),
    .po_busy       (po_busy),
    .po_credit     (po_credit)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present one cycle of inputs, let the edge sample them, then clear them.
  task automatic drive(input logic h, input logic o, input logic c);
    half = h; one = o; cancel = c;
    tick();
    half = 1'b0; one = 1'b0; cancel = 1'b0;
  endtask

  // Records change pulses (offset from now, credit shown) until the controller goes idle.
  task automatic watch_change(input int budget);
    pulse_at.delete();
    pulse_cred.delete();
    idle_at = -1;
    for (int i = 0; i < budget; i++) begin
      if (po_change) begin
        pulse_at.push_back(i);
        pulse_cred.push_back(int'(po_credit));
      end
      if (!po_busy) begin
        idle_at = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({po_cola_req, po_change, po_reject, po_busy, po_credit} !== 8'h00)
      $display("FAIL reset_outputs: got req=%b chg=%b rej=%b busy=%b credit=%0d, expected all 0",
               po_cola_req, po_change, po_reject, po_busy, po_credit);
    else n_pass++;
    half = 1'b1; one = 1'b1;
    tick();
    half = 1'b0; one = 1'b0;
    n_checks++;
    if (po_credit !== 4'd0 || po_busy !== 1'b0)
      $display("FAIL reset_hold: got credit=%0d busy=%b, expected 0/0", po_credit, po_busy);
    else n_pass++;
    sys_rst = 1'b0;
    tick();
    drive(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (po_credit !== 4'd0 || po_busy !== 1'b0 || po_change !== 1'b0)
      $display("FAIL idle_cancel: got credit=%0d busy=%b chg=%b, expected 0/0/0",
               po_credit, po_busy, po_change);
    else n_pass++;
  endtask

  task automatic test_exact_price();
    int exp_cred[3] = '{1, 3, 0};
    logic [1:0] seq[3] = '{2'b01, 2'b10, 2'b10};
    bit bad;
    for (int k = 0; k < 3; k++) begin
      drive(seq[k][0], seq[k][1], 1'b0);
      n_checks++;
      if (po_credit !== 4'(exp_cred[k]) || po_cola_req !== (k == 2))
        $display("FAIL exact_step%0d: got credit=%0d req=%b, expected credit=%0d req=%b",
                 k, po_credit, po_cola_req, exp_cred[k], (k == 2));
      else n_pass++;
    end
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (po_cola_req !== 1'b1 || po_change !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad) $display("FAIL exact_hold: got req dropped or change pulse, expected req held 1 and no change");
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    watch_change(20);
    n_checks++;
    if (po_cola_req !== 1'b0 || idle_at != 0 || pulse_at.size() != 0 || po_credit !== 4'd0)
      $display("FAIL exact_done: got req=%b idle@%0d pulses=%0d credit=%0d, expected 0/0/0/0",
               po_cola_req, idle_at, pulse_at.size(), po_credit);
    else n_pass++;
    $display("txn exact: paid 5 units, refund 0");
  endtask

  task automatic test_random_purchase(input int iters);
    for (int it = 0; it < iters; it++) begin
      int sum, val, dly, left, exp_idle;
      int c;
      bit bad;
      logic cx;
      sum = 0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      while (sum < PRICE) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        c   = $urandom_range(1, 3);
        val = (c % 2) + 2 * (c / 2);
        // a cancel alongside the completing coin must be ignored
        cx  = (sum + val >= PRICE) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(1'(c % 2), 1'(c / 2), cx);
        sum += val;
        n_checks++;
        if (sum < PRICE) begin
          if (po_credit !== 4'(sum) || po_cola_req !== 1'b0)
            $display("FAIL rnd_credit: got credit=%0d req=%b, expected credit=%0d req=0",
                     po_credit, po_cola_req, sum);
          else n_pass++;
        end else begin
          if (po_credit !== 4'(sum - PRICE) || po_cola_req !== 1'b1)
            $display("FAIL rnd_dispense: got credit=%0d req=%b, expected credit=%0d req=1",
                     po_credit, po_cola_req, sum - PRICE);
          else n_pass++;
        end
      end
      left = sum - PRICE;
      dly  = $urandom_range(0, 5);
      bad  = 1'b0;
      for (int k = 0; k < dly; k++) begin
        tick();
        if (po_cola_req !== 1'b1 || po_change !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL rnd_hold: got req dropped or change pulse, expected req held 1");
      else n_pass++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      watch_change(40);
      exp_idle = (left == 0) ? 0 : (left - 1) * GAP + 1;
      n_checks++;
      if (pulse_at.size() != left || idle_at != exp_idle)
        $display("FAIL rnd_refund: got %0d pulses idle@%0d, expected %0d pulses idle@%0d",
                 pulse_at.size(), idle_at, left, exp_idle);
      else n_pass++;
      for (int k = 0; k < pulse_at.size(); k++) begin
        n_checks++;
        if (pulse_at[k] != k * GAP || pulse_cred[k] != left - k)
          $display("FAIL rnd_pulse%0d: got at %0d credit %0d, expected at %0d credit %0d",
                   k, pulse_at[k], pulse_cred[k], k * GAP, left - k);
        else n_pass++;
      end
      $display("txn purchase %0d: paid %0d units, refund %0d", it, sum, left);
    end
  endtask

  task automatic test_cancel(input int iters);
    for (int it = 0; it <= iters; it++) begin
      int sum, val, c, exp_idle;
      sum = 0;
      if (it == 0) begin
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        sum = 3;
      end else begin
        c = $urandom_range(1, 3);
        drive(1'(c % 2), 1'(c / 2), 1'b0);
        sum = (c % 2) + 2 * (c / 2);
        for (int g = $urandom_range(0, 4); g > 0; g--) tick();
        c   = $urandom_range(0, 3);
        val = (c % 2) + 2 * (c / 2);
        if (sum + val >= PRICE) begin c = 0; val = 0; end
        drive(1'(c % 2), 1'(c / 2), 1'b1);
        sum += val;
      end
      watch_change(60);
      exp_idle = (sum - 1) * GAP + 1;
      n_checks++;
      if (pulse_at.size() != sum || idle_at != exp_idle || po_credit !== 4'd0)
        $display("FAIL cancel_refund%0d: got %0d pulses idle@%0d credit=%0d, expected %0d pulses idle@%0d credit=0",
                 it, pulse_at.size(), idle_at, po_credit, sum, exp_idle);
      else n_pass++;
      for (int k = 0; k < pulse_at.size(); k++) begin
        n_checks++;
        if (pulse_at[k] != k * GAP || pulse_cred[k] != sum - k)
          $display("FAIL cancel_pulse%0d: got at %0d credit %0d, expected at %0d credit %0d",
                   k, pulse_at[k], pulse_cred[k], k * GAP, sum - k);
        else n_pass++;
      end
      $display("txn cancel %0d: refund %0d units", it, sum);
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TMO - 1; k++) tick();
    n_checks++;
    if (po_busy !== 1'b0 || po_credit !== 4'd2)
      $display("FAIL timeout_early: got busy=%b credit=%0d at cycle %0d, expected busy=0 credit=2",
               po_busy, po_credit, TMO - 1);
    else n_pass++;
    tick();
    n_checks++;
    if (po_busy !== 1'b1 || po_change !== 1'b1)
      $display("FAIL timeout_entry: got busy=%b chg=%b at cycle %0d, expected 1/1", po_busy, po_change, TMO);
    else n_pass++;
    watch_change(30);
    n_checks++;
    if (pulse_at.size() != 2 || idle_at != GAP + 1)
      $display("FAIL timeout_refund: got %0d pulses idle@%0d, expected 2 pulses idle@%0d",
               pulse_at.size(), idle_at, GAP + 1);
    else n_pass++;
    $display("txn timeout: refund 2 units");
  endtask

  task automatic test_cancel_with_coin();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (po_cola_req !== 1'b1 || po_credit !== 4'd1)
      $display("FAIL cancel_coin: got req=%b credit=%0d, expected req=1 credit=1", po_cola_req, po_credit);
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    watch_change(20);
    n_checks++;
    if (pulse_at.size() != 1 || idle_at != 1)
      $display("FAIL cancel_coin_change: got %0d pulses idle@%0d, expected 1 pulse idle@1",
               pulse_at.size(), idle_at);
    else n_pass++;
    $display("txn cancel+coin: paid 6 units, refund 1");
  endtask

  task automatic test_busy_and_reset();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (po_reject !== 1'b1 || po_credit !== 4'd2 || po_cola_req !== 1'b1)
      $display("FAIL busy_reject: got rej=%b credit=%0d req=%b, expected 1/2/1", po_reject, po_credit, po_cola_req);
    else n_pass++;
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (po_reject !== 1'b1 || po_credit !== 4'd2 || po_busy !== 1'b1)
      $display("FAIL busy_reject2: got rej=%b credit=%0d busy=%b, expected 1/2/1", po_reject, po_credit, po_busy);
    else n_pass++;
    tick();
    n_checks++;
    if (po_reject !== 1'b0 || po_cola_req !== 1'b1)
      $display("FAIL busy_reject_single: got rej=%b req=%b, expected 0/1", po_reject, po_cola_req);
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (po_change !== 1'b1 || po_credit !== 4'd2)
      $display("FAIL busy_change_entry: got chg=%b credit=%0d, expected 1/2", po_change, po_credit);
    else n_pass++;
    tick();
    #2 sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({po_cola_req, po_change, po_reject, po_busy, po_credit} !== 8'h00)
      $display("FAIL midchange_reset: got req=%b chg=%b rej=%b busy=%b credit=%0d, expected all 0",
               po_cola_req, po_change, po_reject, po_busy, po_credit);
    else n_pass++;
    tick();
    sys_rst = 1'b0;
    repeat (GAP + 1) tick();
    n_checks++;
    if (po_busy !== 1'b0 || po_change !== 1'b0 || po_credit !== 4'd0)
      $display("FAIL after_reset: got busy=%b chg=%b credit=%0d, expected 0/0/0", po_busy, po_change, po_credit);
    else n_pass++;
    $display("txn busy/reset: 2 coins rejected, credit lost on reset");
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_random_purchase(12);
    test_cancel(4);
    test_timeout();
    test_cancel_with_coin();
    test_busy_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
